nbit_mul_unit: RTL and testbench

Iterative shift-add multiplier stage sitting directly downstream of the register file read ports and upstream of its write port. It latches two operands (ReadData1/ReadData2) and a destination select on Start, computes the low DATA_WIDTH bits of the unsigned product over multiple cycles, then issues a single-cycle write (WriteData/WriteSelect/WriteEnable) back into the register file. Busy/Done form the handshake to the control unit.

---
 rtl/nbit_mul_pkg.sv | 23 ++
 rtl/nbit_mul_unit_if.sv | 28 ++
 rtl/nbit_adder.sv | 22 ++
 rtl/nbit_mul_unit.sv | 96 +++++++++
 tb/tb_nbit_mul_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/nbit_mul_pkg.sv
// Shared types for the iterative shift-add multiplier.
// FSM state encoding and the counter-width helper.
package nbit_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } mulState_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nbit_mul_unit_if.sv
// Control/regfile bundle for nbit_mul_unit.
// master: drives Start/operands/DestSelect; slave: the multiplier.
interface nbit_mul_unit_if #(
  parameter int REG_SELECT_WIDTH = 5,
  parameter int DATA_WIDTH       = 32
);

  logic                        Start;
  logic [DATA_WIDTH-1:0]       OperandA;
  logic [DATA_WIDTH-1:0]       OperandB;
  logic [REG_SELECT_WIDTH-1:0] DestSelect;
  logic                        Busy;
  logic                        Done;
  logic [DATA_WIDTH-1:0]       WriteData;
  logic [REG_SELECT_WIDTH-1:0] WriteSelect;
  logic                        WriteEnable;

  modport master (
    output Start, OperandA, OperandB, DestSelect,
    input  Busy, Done, WriteData, WriteSelect, WriteEnable
  );

  modport slave (
    input  Start, OperandA, OperandB, DestSelect,
    output Busy, Done, WriteData, WriteSelect, WriteEnable
  );

endinterface

// File: rtl/nbit_adder.sv
// Ripple-carry adder used for the accumulator update.
// Ports: A, B (WIDTH) in; Sum (WIDTH) out, carry-out dropped.
module nbit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum
);

  logic c;

  always_comb begin
    Sum = '0;
    c   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      Sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
  end

endmodule

// File: rtl/nbit_mul_unit.sv
// Iterative shift-add multiplier between regfile read and write ports.
// Ports: Clk, Reset (sync, active-high), bus (nbit_mul_unit_if.slave).
// Option MUL_EARLY_EXIT_EN: leave RUN once remaining multiplier is 0.
module nbit_mul_unit
  import nbit_mul_pkg::*;
#(
  parameter int REG_SELECT_WIDTH = 5,
  parameter int DATA_WIDTH       = 32
) (
  input logic         Clk,
  input logic         Reset,
  nbit_mul_unit_if.slave bus
);

  localparam int CW =
    (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  mulState_e state, stateNext;

  logic [DATA_WIDTH-1:0]       acc, accNext;
  logic [DATA_WIDTH-1:0]       aReg, aNext;
  logic [DATA_WIDTH-1:0]       bReg, bNext;
  logic [REG_SELECT_WIDTH-1:0] destReg, destNext;
  logic [CW-1:0]               count, countNext;
  logic [DATA_WIDTH-1:0]       sum;
  logic                        lastRun;

  nbit_adder #(.WIDTH(DATA_WIDTH)) uAdder (
    .A   (acc),
    .B   (aReg),
    .Sum (sum)
  );

`ifdef MUL_EARLY_EXIT_EN
  assign lastRun = (count == LAST) || ((bReg >> 1) == '0);
`else
  assign lastRun = (count == LAST);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      acc     <= '0;
      aReg    <= '0;
      bReg    <= '0;
      destReg <= '0;
      count   <= '0;
    end else begin
      state   <= stateNext;
      acc     <= accNext;
      aReg    <= aNext;
      bReg    <= bNext;
      destReg <= destNext;
      count   <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    accNext   = acc;
    aNext     = aReg;
    bNext     = bReg;
    destNext  = destReg;
    countNext = count;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          accNext   = '0;
          aNext     = bus.OperandA;
          bNext     = bus.OperandB;
          destNext  = bus.DestSelect;
          countNext = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (bReg[0]) accNext = sum;
        aNext     = aReg << 1;
        bNext     = bReg >> 1;
        countNext = count + CW'(1);
        if (lastRun) stateNext = WRITE;
      end
      WRITE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Data/select always mirror the registers; WriteEnable qualifies them.
  assign bus.Busy        = (state != IDLE);
  assign bus.Done        = (state == WRITE);
  assign bus.WriteEnable = (state == WRITE);
  assign bus.WriteData   = acc;
  assign bus.WriteSelect = destReg;

endmodule

// File: tb/tb_nbit_mul_unit.sv
// Self-checking bench for nbit_mul_unit.
// Table of directed products plus start-hold and mid-op reset cases.
module tb_nbit_mul_unit;

  localparam int DW     = 32;
  localparam int RSW    = 5;
  localparam int BUDGET = 45;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  nbit_mul_unit_if #(
    .REG_SELECT_WIDTH(RSW),
    .DATA_WIDTH(DW)
  ) bus ();

  nbit_mul_unit #(
    .REG_SELECT_WIDTH(RSW),
    .DATA_WIDTH(DW)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [RSW-1:0] d;
    logic [DW-1:0]  p;
  } vec_t;

  vec_t tbl [9];

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Cycles from the Start-sampling edge to WriteEnable seen.
  function automatic int expLat(input logic [DW-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int n;
    n = 1;
    for (int i = 0; i < DW; i++)
      if (b[i]) n = i + 1;
    return n + 1;
`else
    return DW + 1;
`endif
  endfunction

  task automatic startOp(input logic [DW-1:0] a,
                         input logic [DW-1:0] b,
                         input logic [RSW-1:0] d);
    @(negedge clk);
    bus.Start      = 1'b1;
    bus.OperandA   = a;
    bus.OperandB   = b;
    bus.DestSelect = d;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic waitWe(inout int k);
    while (bus.WriteEnable !== 1'b1 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic runOp(input logic [DW-1:0] a,
                       input logic [DW-1:0] b,
                       input logic [RSW-1:0] d,
                       input logic [DW-1:0] p,
                       input string name);
    int k;
    startOp(a, b, d);
    k = 1;
    chk({name, " busy"}, DW'(bus.Busy), 1);
    waitWe(k);
    chk({name, " lat"}, k, expLat(b));
    chk({name, " data"}, bus.WriteData, p);
    chk({name, " sel"}, DW'(bus.WriteSelect), DW'(d));
    chk({name, " done"}, DW'(bus.Done), 1);
    @(negedge clk);
    chk({name, " we off"}, DW'(bus.WriteEnable), 0);
    chk({name, " done off"}, DW'(bus.Done), 0);
    chk({name, " idle"}, DW'(bus.Busy), 0);
  endtask

  initial begin
    int k;
    int pulses;

    tbl[0] = '{32'd3, 32'd5, 5'd7, 32'd15};
    tbl[1] = '{32'hFFFF_FFFF, 32'd2, 5'd31, 32'hFFFF_FFFE};
    tbl[2] = '{32'd0, 32'h1234, 5'd1, 32'd0};
    tbl[3] = '{32'h1234_5678, 32'd1, 5'd2, 32'h1234_5678};
    tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'd1};
    tbl[5] = '{32'h0001_0000, 32'h0001_0000, 5'd4, 32'd0};
    tbl[6] = '{32'hFFFF_FFFD, 32'd7, 5'd5, 32'hFFFF_FFEB};
    tbl[7] = '{32'd1234, 32'd5678, 5'd6, 32'd7006652};
    tbl[8] = '{32'h8000_0000, 32'd3, 5'd8, 32'h8000_0000};

    bus.Start      = 1'b0;
    bus.OperandA   = '0;
    bus.OperandB   = '0;
    bus.DestSelect = '0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst busy", DW'(bus.Busy), 0);
    chk("rst done", DW'(bus.Done), 0);
    chk("rst we", DW'(bus.WriteEnable), 0);
    chk("rst data", bus.WriteData, 0);
    chk("rst sel", DW'(bus.WriteSelect), 0);

    for (int i = 0; i < 9; i++)
      runOp(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].p,
            $sformatf("vec%0d", i));

    // Start held through the op with new operands: no re-sample.
    @(negedge clk);
    bus.Start      = 1'b1;
    bus.OperandA   = 32'd3;
    bus.OperandB   = 32'd5;
    bus.DestSelect = 5'd7;
    @(negedge clk);
    bus.OperandA   = 32'd9;
    bus.OperandB   = 32'd9;
    bus.DestSelect = 5'd9;
    k = 1;
    waitWe(k);
    chk("hold lat1", k, expLat(32'd5));
    chk("hold data1", bus.WriteData, 32'd15);
    chk("hold sel1", DW'(bus.WriteSelect), 32'd7);
    @(negedge clk);
    chk("hold idle", DW'(bus.Busy), 0);
    @(negedge clk);
    chk("hold busy2", DW'(bus.Busy), 1);
    bus.Start = 1'b0;
    k = 1;
    waitWe(k);
    chk("hold lat2", k, expLat(32'd9));
    chk("hold data2", bus.WriteData, 32'd81);
    chk("hold sel2", DW'(bus.WriteSelect), 32'd9);
    @(negedge clk);

    // Reset during RUN: op abandoned, no write afterwards.
    startOp(32'd3, 32'hFFFF_FFFF, 5'd12);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst busy", DW'(bus.Busy), 0);
    chk("mrst we", DW'(bus.WriteEnable), 0);
    chk("mrst data", bus.WriteData, 0);
    chk("mrst sel", DW'(bus.WriteSelect), 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.WriteEnable === 1'b1) pulses++;
    end
    chk("mrst no write", pulses, 0);
    runOp(32'd2, 32'd4, 5'd3, 32'd8, "post rst");

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end

endmodule
